// File: rtl/bus_arbiter.sv
// bus_arbiter: central arbiter and sequencer for the shared 8-bit bus.
// Picks one of four agents (agent 3 has absolute priority, agents 0..2 rotate),
// issues a one-cycle header byte, idles the bus for TURN cycles, then grants
// the bus to the owner until its last byte or a request withdrawal.
// Optional feature: define ARB_TIMEOUT_EN to abort an owner that stays silent
// for TIMEOUT consecutive XFER cycles. Without it, abort is tied low and XFER
// waits indefinitely.
module bus_arbiter #(
  parameter int TURN    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [7:0] req_dest,
  input  logic [3:0] last,
  input  logic       xfer_valid,
  output logic [3:0] gnt,
  output logic       hdr_valid,
  output logic [7:0] hdr_data,
  output logic       busy,
  output logic [1:0] cur_src,
  output logic [1:0] cur_dest,
  output logic       abort
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    WAIT = 2'd2,
    XFER = 2'd3
  } arbState_t;

  generate
    if (TURN < 1 || TURN > 7) begin : gTurnRange
      $error("bus_arbiter: TURN must be in 1..7");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : gTimeoutRange
      $error("bus_arbiter: TIMEOUT must be in 2..255");
    end
  endgenerate

  arbState_t  r_state;
  arbState_t  w_nextState;
  logic [1:0] r_rrPtr;
  logic [2:0] r_turnCnt;
  logic [1:0] r_curSrc;
  logic [1:0] r_curDest;

  logic [1:0] w_winner;
  logic [1:0] w_winnerDest;
  logic       w_ownerReq;
  logic       w_ownerDone;
  logic       w_timeout;
  logic       w_leave;

  // Arbitration: agent 3 always wins, otherwise rotate over 0..2 from r_rrPtr
  always_comb begin
    w_winner = 2'd0;
    if (req[3]) begin
      w_winner = 2'd3;
    end else begin
      case (r_rrPtr)
        2'd1:    w_winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
        2'd2:    w_winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
        default: w_winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
    end
  end

  // Destination field belonging to the current winner
  always_comb begin
    w_winnerDest = 2'd0;
    case (w_winner)
      2'd0:    w_winnerDest = req_dest[1:0];
      2'd1:    w_winnerDest = req_dest[3:2];
      2'd2:    w_winnerDest = req_dest[5:4];
      default: w_winnerDest = req_dest[7:6];
    endcase
  end

  // Owner-side completion: final byte on the bus, or the owner dropped its request
  always_comb begin
    w_ownerReq  = req[r_curSrc];
    w_ownerDone = (xfer_valid && last[r_curSrc]) || !w_ownerReq;
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_silentCnt;

  // Silence counter: zero outside XFER and on every byte, counts silent XFER cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_silentCnt <= 8'd0;
    end else if (r_state != XFER || xfer_valid) begin
      r_silentCnt <= 8'd0;
    end else begin
      r_silentCnt <= r_silentCnt + 8'd1;
    end
  end

  assign w_timeout = (r_state == XFER) && !xfer_valid && w_ownerReq &&
                     (r_silentCnt == 8'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign abort = w_timeout;

  // Any exit back to IDLE after the header counts as a finished transaction
  assign w_leave = ((r_state == WAIT) && !w_ownerReq) ||
                   ((r_state == XFER) && (w_ownerDone || w_timeout));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic for the IDLE -> HDR -> WAIT -> XFER sequence
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (|req) w_nextState = HDR;
      HDR:  w_nextState = WAIT;
      WAIT: begin
        if (!w_ownerReq) begin
          w_nextState = IDLE;
        end else if (r_turnCnt == 3'(TURN - 1)) begin
          w_nextState = XFER;
        end
      end
      XFER: if (w_ownerDone || w_timeout) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs decoded purely from state so reset clears them asynchronously
  always_comb begin
    gnt       = 4'b0000;
    hdr_valid = 1'b0;
    hdr_data  = 8'h00;
    busy      = (r_state != IDLE);
    if (r_state == HDR) begin
      hdr_valid = 1'b1;
      hdr_data  = {2'b00, r_curDest, r_curSrc, 2'b00};
    end
    if (r_state == XFER) begin
      gnt[r_curSrc] = 1'b1;
    end
  end

  // Latch the winner's source and destination at the IDLE decision edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_curSrc  <= 2'd0;
      r_curDest <= 2'd0;
    end else if (r_state == IDLE && (|req)) begin
      r_curSrc  <= w_winner;
      r_curDest <= w_winnerDest;
    end
  end

  // Turnaround counter runs only in WAIT and rewinds on the final WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_turnCnt <= 3'd0;
    end else if (r_state == WAIT && r_turnCnt != 3'(TURN - 1)) begin
      r_turnCnt <= r_turnCnt + 3'd1;
    end else begin
      r_turnCnt <= 3'd0;
    end
  end

  // Round-robin pointer moves past the finished owner; agent 3 leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr <= 2'd0;
    end else if (w_leave && r_curSrc != 2'd3) begin
      r_rrPtr <= (r_curSrc == 2'd2) ? 2'd0 : r_curSrc + 2'd1;
    end
  end

  assign cur_src  = r_curSrc;
  assign cur_dest = r_curDest;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter. Expected header/grant
// pairs are queued when requests are driven and consumed by a monitor that
// checks each header byte and the grant TURN+1 cycles later.
module tb_bus_arbiter;

  localparam int TURN    = 3;
  localparam int TIMEOUT = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] req_dest;
  logic [3:0] last;
  logic       xfer_valid;
  logic [3:0] gnt;
  logic       hdr_valid;
  logic [7:0] hdr_data;
  logic       busy;
  logic [1:0] cur_src;
  logic [1:0] cur_dest;
  logic       abort;

  typedef struct {
    logic [7:0] hdr;
    logic [3:0] grant;
  } expTxn_t;

  expTxn_t expQ[$];
  int      checkCount = 0;
  int      failCount  = 0;
  int      gntWait    = 0;
  logic [3:0] expGnt  = 4'b0000;

  bus_arbiter #(.TURN(TURN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dest(req_dest), .last(last),
    .xfer_valid(xfer_valid), .gnt(gnt), .hdr_valid(hdr_valid),
    .hdr_data(hdr_data), .busy(busy), .cur_src(cur_src),
    .cur_dest(cur_dest), .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Monitor: pop the expected header when one appears, then check the
  // quiet turnaround and the grant that follows it
  always @(negedge clk) begin
    if (!rst_n) begin
      gntWait = 0;
    end else if (hdr_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedHdr", {24'd0, hdr_data}, 32'hFFFF_FFFF);
      end else begin
        expTxn_t t;
        t = expQ.pop_front();
        checkOutput("hdrData", {24'd0, hdr_data}, {24'd0, t.hdr});
        checkOutput("hdrGntLow", {28'd0, gnt}, 32'd0);
        expGnt  = t.grant;
        gntWait = TURN + 1;
      end
    end else if (gntWait > 0) begin
      gntWait = gntWait - 1;
      if (gntWait == 0) begin
        checkOutput("gntLatency", {28'd0, gnt}, {28'd0, expGnt});
      end else begin
        checkOutput("turnQuiet", {27'd0, hdr_valid, gnt}, 32'd0);
      end
    end
  end

  // Drive a new request pattern just after a rising edge
  task automatic applyStimulus(input logic [3:0] newReq, input logic [7:0] newDest);
    @(posedge clk);
    #1;
    req      = newReq;
    req_dest = newDest;
  endtask

  task automatic pushExp(input logic [7:0] hdr, input logic [3:0] grant);
    expTxn_t t;
    t.hdr   = hdr;
    t.grant = grant;
    expQ.push_back(t);
  endtask

  // Reset with noisy inputs; gnt must drop the moment rst_n falls
  task automatic applyReset();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstAsyncGnt", {28'd0, gnt}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      req        = 4'($urandom);
      req_dest   = 8'($urandom);
      last       = 4'($urandom);
      xfer_valid = 1'($urandom);
      @(negedge clk);
      checkOutput("rstOutputs",
                  {14'd0, gnt, hdr_valid, hdr_data, busy, cur_src, cur_dest, abort},
                  32'd0);
    end
    #1;
    req = 4'd0; req_dest = 8'd0; last = 4'd0; xfer_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idleAfterRst", {30'd0, busy, hdr_valid}, 32'd0);
  endtask

  // Bounded wait for the given agent to be granted
  task automatic waitGrant(input int src);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (gnt[src]) break;
    end
    checkOutput($sformatf("grantSeen%0d", src), {31'd0, gnt[src]}, 32'd1);
  endtask

  // Owner sends nBytes, last on the final one; req takes reqAtLast with it
  task automatic serveOwner(input int src, input int nBytes, input logic [3:0] reqAtLast);
    for (int b = 1; b <= nBytes; b++) begin
      xfer_valid = 1'b1;
      last       = 4'd0;
      if (b == nBytes) begin
        last[src] = 1'b1;
        req       = reqAtLast;
      end
      @(posedge clk);
      #1;
      xfer_valid = 1'b0;
      last       = 4'd0;
    end
    checkOutput("gntRelease", {28'd0, gnt}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; req = 4'd0; req_dest = 8'd0; last = 4'd0; xfer_valid = 1'b0;
    @(posedge clk);

    // Single transaction from agent 0 to agent 2
    applyReset();
    pushExp(8'h20, 4'b0001);
    applyStimulus(4'b0001, 8'b0000_0010);
    waitGrant(0);
    serveOwner(0, 1, 4'b0000);
    checkOutput("busyAfterDone", {31'd0, busy}, 32'd0);

    // Round-robin rotation with all of agents 0..2 requesting
    applyReset();
    pushExp(8'h10, 4'b0001);
    pushExp(8'h24, 4'b0010);
    pushExp(8'h38, 4'b0100);
    pushExp(8'h10, 4'b0001);
    applyStimulus(4'b0111, 8'b0011_1001);
    waitGrant(0); serveOwner(0, 2, 4'b0111);
    waitGrant(1); serveOwner(1, 2, 4'b0111);
    waitGrant(2); serveOwner(2, 2, 4'b0111);
    waitGrant(0); serveOwner(0, 2, 4'b0000);

    // Control agent preempts the rotation
    applyReset();
    pushExp(8'h1C, 4'b1000);
    pushExp(8'h30, 4'b0001);
    applyStimulus(4'b1001, 8'b0100_0011);
    waitGrant(3); serveOwner(3, 1, 4'b0001);
    waitGrant(0); serveOwner(0, 1, 4'b0000);

    // Ignored last bits; also src == dest
    applyReset();
    pushExp(8'h14, 4'b0010);
    applyStimulus(4'b0010, 8'b0000_0100);
    waitGrant(1);
    last = 4'b0110; xfer_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("lastNoValid", {28'd0, gnt}, 32'h2);
    last = 4'b0100; xfer_valid = 1'b1;
    @(posedge clk); #1;
    checkOutput("lastNonOwner", {28'd0, gnt}, 32'h2);
    last = 4'd0; xfer_valid = 1'b0;
    serveOwner(1, 1, 4'b0000);

    // Withdrawal in XFER ends quietly and advances the rotation past agent 1
    applyReset();
    pushExp(8'h04, 4'b0010);
    applyStimulus(4'b0010, 8'b0000_0000);
    waitGrant(1);
    req = 4'b0000;
    @(posedge clk); #1;
    checkOutput("withdrawGnt", {28'd0, gnt}, 32'd0);
    checkOutput("withdrawAbortBusy", {30'd0, abort, busy}, 32'd0);
    pushExp(8'h18, 4'b0100);
    pushExp(8'h30, 4'b0001);
    applyStimulus(4'b0101, 8'b0001_0011);
    waitGrant(2); serveOwner(2, 1, 4'b0001);
    waitGrant(0); serveOwner(0, 1, 4'b0000);

    // Silent owner with agent 2 pending
    applyReset();
    pushExp(8'h00, 4'b0001);
    pushExp(8'h08, 4'b0100);
    applyStimulus(4'b0101, 8'b0000_0000);
    waitGrant(0);
`ifdef ARB_TIMEOUT_EN
    for (int j = 1; j < TIMEOUT; j++) begin
      checkOutput("noEarlyAbort", {31'd0, abort}, 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("abortPulse", {31'd0, abort}, 32'd1);
    checkOutput("gntAtAbort", {28'd0, gnt}, 32'h1);
    @(posedge clk); #1;
    checkOutput("abortOneCycle", {31'd0, abort}, 32'd0);
    checkOutput("gntAfterAbort", {28'd0, gnt}, 32'd0);
    req = 4'b0100;
`else
    for (int j = 0; j < 40; j++) begin
      checkOutput("abortTiedLow", {27'd0, abort, gnt}, 32'h1);
      @(posedge clk); #1;
    end
    serveOwner(0, 1, 4'b0100);
`endif
    waitGrant(2); serveOwner(2, 1, 4'b0000);

    // Reset in the middle of a transfer
    applyReset();
    pushExp(8'h00, 4'b0001);
    applyStimulus(4'b0001, 8'b0000_0000);
    waitGrant(0);
    applyReset();

    repeat (3) @(posedge clk);
    checkOutput("sbDrain", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central arbiter and sequencer for the shared 8-bit data bus between the four bus agents (IDs 0..3; ID 3 is the control agent).
- Selects one requester and drives the transaction header byte onto the bus.
- Holds the bus idle for a fixed turnaround window, then grants ownership until the owner signals its last byte.
- Sits beside the per-agent data_bus interfaces and drives their send-side gating.

Parameters:
- TURN, 3: idle cycles between the header cycle and the grant (1..7).
- TIMEOUT, 16: cycles of owner silence in XFER before abort (2..255; used only with ARB_TIMEOUT_EN).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  per-agent bus request, bit i = agent ID i.
- req_dest  input  8  per-agent destination ID; agent i uses bits [2i+1:2i].
- last  input  4  per-agent marker that the current byte is the final one.
- xfer_valid  input  1  a byte is present on the bus this cycle (owner driving).
- gnt  output  4  one-hot bus grant.
- hdr_valid  output  1  arbiter drives header byte this cycle.
- hdr_data  output  8  header byte.
- busy  output  1  transaction in progress.
- cur_src  output  2  latched source ID.
- cur_dest  output  2  latched destination ID.
- abort  output  1  one-cycle pulse: transaction forcibly ended.

Behaviour:
- Reset (async): all outputs 0; state IDLE; rr_ptr=0; turnaround counter 0; timeout counter 0.
- States: IDLE -> HDR -> WAIT -> XFER -> IDLE. busy=1 in every state except IDLE.
- IDLE arbitration, at each edge with any req bit set:
  - req[3] wins unconditionally.
  - Otherwise round-robin over IDs 0..2, searching from rr_ptr upward with wrap.
  - Latch cur_src = winner and cur_dest = req_dest of the winner; go to HDR.
- HDR (exactly 1 cycle):
  - hdr_valid=1.
  - hdr_data = {2'b00, cur_dest, cur_src, 2'b00}.
  - Go to WAIT.
- WAIT: exactly TURN cycles; gnt=0 and hdr_valid=0 throughout; then go to XFER.
- XFER:
  - gnt[cur_src]=1; all other gnt bits 0.
  - Leave to IDLE on an edge where xfer_valid=1 and last[cur_src]=1; gnt clears the following cycle.
- Latency: req sampled at edge N gives hdr_valid in cycle N+1, WAIT in N+2..N+1+TURN, gnt from N+2+TURN.
- IDLE lasts at least 1 cycle between transactions; no back-to-back header.
- rr_ptr update on leaving XFER: if cur_src<3, rr_ptr=(cur_src+1) mod 3; unchanged after an ID-3 transaction.
- Ignored inputs:
  - last bits of non-owners.
  - last[cur_src] with xfer_valid=0.
  - req changes after latching, except withdrawal (below).
- Withdrawal: req[cur_src]=0 during WAIT or XFER -> return to IDLE next edge, no abort, rr_ptr updated as a normal completion.
- Same-cycle last and withdrawal: treat as a normal completion.
- src==dest is legal; header issued unchanged.
- req_dest of the winner is sampled only at the IDLE decision edge.
- Reset asserted mid-transaction: immediate return to reset values, gnt drops asynchronously.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - 8-bit counter clears on entering XFER and on every xfer_valid=1 cycle; increments on other XFER cycles.
  - When it reaches TIMEOUT: abort=1 for one cycle, gnt clears, go to IDLE, rr_ptr updated as normal completion.
- When undefined: no counter is instantiated; abort is tied 0; XFER waits indefinitely.

Test Plan:
1. Hold rst_n=0 with random inputs -> gnt=0, hdr_valid=0, hdr_data=0x00, busy=0, abort=0; deassert -> state IDLE.
2. req=0001 (ID 0), req_dest[1:0]=2 asserted before edge N, TURN=3 -> hdr_valid only in cycle N+1 with hdr_data=0x20; gnt=0001 from N+5; after xfer_valid with last[0] on one byte -> gnt=0 next cycle, busy=0.
3. req=0111 held; each owner sends 2 bytes with last on byte 2 -> grant order 0,1,2,0; each header carries matching src bits (0x00/0x04/0x08 | dest<<4).
4. rr_ptr=0, req=1001, req_dest[7:6]=1 -> ID 3 granted first, hdr_data=0x1C; ID 0 granted next.
5. Owner ID 1 in XFER; pulse last[2]=1 and last[1]=1 with xfer_valid=0 -> gnt stays 0010; then last[1]=1 with xfer_valid=1 -> release.
6. With ARB_TIMEOUT_EN and TIMEOUT=16, owner silent in XFER -> abort pulses 1 cycle on the 16th silent cycle, gnt clears, a pending req[2] is headered next; without the macro, abort stays 0 and gnt holds.
